// File: rtl/stereo_decimator_if.sv
// Sample bus between the stereo source, the boxcar decimator and the echo stage.
// master drives samples in, slave is the decimator.
interface stereo_decimator_if #(
   parameter int unsigned W = 16
);
   logic                sample_clk;
   logic signed [W-1:0] sample_in0;
   logic signed [W-1:0] sample_in1;
   logic signed [W-1:0] sample_out0;
   logic signed [W-1:0] sample_out1;
   logic                decimate_clk;
   logic                out_strobe;

   modport master (
      output sample_clk, sample_in0, sample_in1,
      input  sample_out0, sample_out1, decimate_clk, out_strobe
   );

   modport slave (
      input  sample_clk, sample_in0, sample_in1,
      output sample_out0, sample_out1, decimate_clk, out_strobe
   );
endinterface

// File: rtl/stereo_decimator.sv
// Two-channel boxcar decimator: averages blocks of 2^(DECIMATE+1) samples per
// channel and emits a reduced-rate clock plus a one-cycle strobe per output.
module stereo_decimator #(
   parameter int unsigned W        = 16,
   parameter int unsigned DECIMATE = 2
) (
   input logic             clk,
   input logic             rst,
   stereo_decimator_if.slave bus
);
   localparam int unsigned CW   = DECIMATE + 1;
   localparam int unsigned AW   = W + CW;
   localparam int unsigned R    = 1 << CW;
   localparam logic [CW-1:0] LAST = CW'(R - 1);
   localparam logic [CW-1:0] HALF = CW'(R / 2);

   typedef enum logic {ACCUM = 1'b0, DUMP = 1'b1} state_t;

   state_t               state, state_nxt;
   logic                 sample_clk_q;
   logic                 edge_c;
   logic signed [AW-1:0] ext0_c, ext1_c;
   logic signed [AW-1:0] acc0, acc1, acc0_nxt, acc1_nxt;
   logic signed [AW-1:0] sum_q0, sum_q1, sum0_nxt, sum1_nxt;
   logic [CW-1:0]        count, count_nxt;
   logic signed [W-1:0]  out0_q, out1_q, out0_nxt, out1_nxt;
   logic                 dclk_q, dclk_nxt;
   logic                 strobe_q, strobe_nxt;

   assign edge_c = bus.sample_clk & ~sample_clk_q;
   assign ext0_c = {{CW{bus.sample_in0[W-1]}}, bus.sample_in0};
   assign ext1_c = {{CW{bus.sample_in1[W-1]}}, bus.sample_in1};

   // sample_clk_q resets high so a level already high at release is not an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ACCUM;
         sample_clk_q <= 1'b1;
         acc0         <= '0;
         acc1         <= '0;
         sum_q0       <= '0;
         sum_q1       <= '0;
         count        <= '0;
         out0_q       <= '0;
         out1_q       <= '0;
         dclk_q       <= 1'b0;
         strobe_q     <= 1'b0;
      end else begin
         state        <= state_nxt;
         sample_clk_q <= bus.sample_clk;
         acc0         <= acc0_nxt;
         acc1         <= acc1_nxt;
         sum_q0       <= sum0_nxt;
         sum_q1       <= sum1_nxt;
         count        <= count_nxt;
         out0_q       <= out0_nxt;
         out1_q       <= out1_nxt;
         dclk_q       <= dclk_nxt;
         strobe_q     <= strobe_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      acc0_nxt   = acc0;
      acc1_nxt   = acc1;
      sum0_nxt   = sum_q0;
      sum1_nxt   = sum_q1;
      count_nxt  = count;
      out0_nxt   = out0_q;
      out1_nxt   = out1_q;
      dclk_nxt   = dclk_q;
      strobe_nxt = 1'b0;

      // Publish the block average; arithmetic shift floors toward -inf
      if (state == DUMP) begin
         out0_nxt   = W'(sum_q0 >>> CW);
         out1_nxt   = W'(sum_q1 >>> CW);
         strobe_nxt = 1'b1;
         dclk_nxt   = 1'b1;
         state_nxt  = ACCUM;
      end

      // An edge during DUMP lands in the already-cleared accumulators
      if (edge_c) begin
         if (count == LAST) begin
            sum0_nxt  = acc0 + ext0_c;
            sum1_nxt  = acc1 + ext1_c;
            acc0_nxt  = '0;
            acc1_nxt  = '0;
            count_nxt = '0;
            state_nxt = DUMP;
         end else begin
            acc0_nxt  = acc0 + ext0_c;
            acc1_nxt  = acc1 + ext1_c;
            count_nxt = count + CW'(1);
            if ((count + CW'(1)) == HALF && state == ACCUM)
               dclk_nxt = 1'b0;
         end
      end
   end

   assign bus.sample_out0  = out0_q;
   assign bus.sample_out1  = out1_q;
   assign bus.decimate_clk = dclk_q;
   assign bus.out_strobe   = strobe_q;
endmodule

// File: tb/tb_stereo_decimator.sv
// Directed bench for stereo_decimator at W=16, DECIMATE=2 (blocks of 8 samples).
module tb_stereo_decimator;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   logic mid_strobe;

   stereo_decimator_if #(.W(16)) bus ();

   stereo_decimator #(.W(16), .DECIMATE(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One sample period: high for one clk, low for one clk; returns on a negedge
   task automatic send(input logic signed [15:0] a, input logic signed [15:0] b);
      bus.sample_clk = 1'b1;
      bus.sample_in0 = a;
      bus.sample_in1 = b;
      @(negedge clk);
      mid_strobe     = bus.out_strobe;
      bus.sample_clk = 1'b0;
      bus.sample_in0 = 16'sh5A5A;
      bus.sample_in1 = 16'sh5A5A;
      @(negedge clk);
   endtask

   initial begin
      logic signed [15:0] ramp1;
      n_cmp = 0;
      n_err = 0;
      mid_strobe = 1'b0;
      rst = 1'b1;
      bus.sample_clk = 1'b0;
      bus.sample_in0 = '0;
      bus.sample_in1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_out0", bus.sample_out0, 0);
      chk("rst_out1", bus.sample_out1, 0);
      chk("rst_strobe", bus.out_strobe, 0);
      chk("rst_dclk", bus.decimate_clk, 0);
      rst = 1'b0;
      @(negedge clk);

      // Constant input over two blocks, with decimate_clk duty and strobe spacing
      for (int i = 0; i < 16; i++) begin
         send(16'sd1000, -16'sd1);
         chk($sformatf("const_strobe_%0d", i), bus.out_strobe,
             (i == 7 || i == 15) ? 1 : 0);
         chk($sformatf("const_dclk_%0d", i), bus.decimate_clk,
             (i < 7) ? 0 : (((i - 7) % 8) < 4 ? 1 : 0));
         if (i >= 7) begin
            chk($sformatf("const_out0_%0d", i), bus.sample_out0, 1000);
            chk($sformatf("const_out1_%0d", i), bus.sample_out1, -1);
         end
         if (i == 7) chk("const_latency_mid", mid_strobe, 0);
      end
      @(negedge clk);
      chk("const_strobe_width", bus.out_strobe, 0);

      // Ramp on ch0, floor rounding on ch1
      for (int i = 0; i < 8; i++) begin
         ramp1 = (i == 0) ? -16'sd3 : 16'sd0;
         send(16'(i), ramp1);
      end
      chk("ramp_strobe", bus.out_strobe, 1);
      chk("ramp_out0", bus.sample_out0, 3);
      chk("ramp_out1", bus.sample_out1, -1);

      // Full scale, both polarities on each channel
      repeat (8) send(16'sh7FFF, 16'sh8000);
      chk("fs_out0_pos", bus.sample_out0, 32767);
      chk("fs_out1_neg", bus.sample_out1, -32768);
      repeat (8) send(16'sh8000, 16'sh7FFF);
      chk("fs_out0_neg", bus.sample_out0, -32768);
      chk("fs_out1_pos", bus.sample_out1, 32767);

      // Mid-block reset discards the partial block
      repeat (5) send(16'sd5000, 16'sd5000);
      rst = 1'b1;
      #1;
      chk("midrst_out0", bus.sample_out0, 0);
      chk("midrst_out1", bus.sample_out1, 0);
      chk("midrst_strobe", bus.out_strobe, 0);
      chk("midrst_dclk", bus.decimate_clk, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         send(16'sd200, 16'sd200);
         chk($sformatf("midrst_strobe_%0d", i), bus.out_strobe, (i == 7) ? 1 : 0);
      end
      chk("midrst_out0_after", bus.sample_out0, 200);
      chk("midrst_out1_after", bus.sample_out1, 200);

      // Reset released while sample_clk is already high: that level is not an edge
      rst = 1'b1;
      bus.sample_clk = 1'b1;
      bus.sample_in0 = 16'sd7777;
      bus.sample_in1 = 16'sd7777;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      bus.sample_clk = 1'b0;
      @(negedge clk);
      chk("hirel_out0", bus.sample_out0, 0);
      chk("hirel_strobe", bus.out_strobe, 0);
      for (int i = 0; i < 8; i++) begin
         send(-16'sd100, 16'sd300);
         chk($sformatf("hirel_strobe_%0d", i), bus.out_strobe, (i == 7) ? 1 : 0);
      end
      chk("hirel_out0_after", bus.sample_out0, -100);
      chk("hirel_out1_after", bus.sample_out1, 300);

      // Outputs hold between strobes
      repeat (4) @(negedge clk);
      chk("hold_out0", bus.sample_out0, -100);
      chk("hold_strobe", bus.out_strobe, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
